// File: rtl/interboard_receiver.sv
// Receive end of the 4-phase Request/Ack interboard link: reassembles 2-beat frames into messages.
// Optional inter-beat timeout is compiled in when INTER_RX_TIMEOUT_EN is defined.
module interboard_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [2:0]  RST_TYPE       = 3'd7,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  output logic       rx_busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StCap, StAckHi, StAckLo} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [5:0]             r_data_sync [SYNC_STAGES];
  logic                   w_req_s;
  logic [5:0]             w_data_s;

  logic [5:0] r_data_cap;
  logic       r_beat_idx;
  logic [2:0] r_type_hold;
  logic [1:0] r_num_hi;
  logic       r_en;
  logic       r_rst;
  logic       r_err;
  logic [2:0] r_msg_type;
  logic [4:0] r_number;
  logic       w_cap;
  logic       w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
    end else begin
      r_req_sync     <= {r_req_sync[SYNC_STAGES-2:0], Request_in};
      r_data_sync[0] <= inter_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
    end
  end

  assign w_req_s  = r_req_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // ACK_LO always lasts one cycle so the sender sees a real low phase on Ack.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_req_s) w_state_nxt = StCap;
      StCap:   w_state_nxt = StAckHi;
      StAckHi: if (!w_req_s) w_state_nxt = StAckLo;
      StAckLo: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_cap = (r_state == StCap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_cap  <= '0;
      r_beat_idx  <= 1'b0;
      r_type_hold <= '0;
      r_num_hi    <= '0;
      r_en        <= 1'b0;
      r_rst       <= 1'b0;
      r_err       <= 1'b0;
      r_msg_type  <= '0;
      r_number    <= '0;
    end else begin
      r_en  <= 1'b0;
      r_rst <= 1'b0;
      r_err <= 1'b0;
      if (r_state == StIdle && w_req_s) r_data_cap <= w_data_s;
      if (w_cap) begin
        if (!r_beat_idx) begin
          if (r_data_cap[5]) begin
            r_type_hold <= r_data_cap[4:2];
            r_num_hi    <= r_data_cap[1:0];
            r_beat_idx  <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else if (!r_data_cap[5]) begin
          r_en       <= 1'b1;
          r_rst      <= (r_type_hold == RST_TYPE);
          r_msg_type <= r_type_hold;
          r_number   <= {r_num_hi, r_data_cap[2:0]};
          r_beat_idx <= 1'b0;
        end else begin
          // Unexpected beat 0: drop the partial frame and restart from this beat.
          r_err       <= 1'b1;
          r_type_hold <= r_data_cap[4:2];
          r_num_hi    <= r_data_cap[1:0];
        end
      end else if (w_timeout) begin
        r_err      <= 1'b1;
        r_beat_idx <= 1'b0;
      end
    end
  end

`ifdef INTER_RX_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  assign w_timeout = r_beat_idx && (r_state == StIdle) && (r_to_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_state_nxt == StCap) begin
      r_to_cnt <= '0;
    end else if (r_beat_idx && r_state == StIdle) begin
      if (w_timeout) r_to_cnt <= '0;
      else           r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign Ack_out             = (r_state == StAckHi);
  assign interboard_en       = r_en;
  assign interboard_rst      = r_rst;
  assign interboard_msg_type = r_msg_type;
  assign interboard_number   = r_number;
  assign rx_busy             = r_beat_idx;
  assign frame_err           = r_err;

endmodule

// File: tb/tb_interboard_receiver.sv
// Directed bench for interboard_receiver: drives 4-phase beats and checks decoded messages.
module tb_interboard_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Request_in;
  logic [5:0] inter_data_in;
  logic       Ack_out;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       interboard_rst;
  logic       rx_busy;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  int n_en = 0, n_rst = 0, n_err = 0, n_ack = 0, n_coinc = 0;
  logic ack_prev = 1'b0;
  bit   seen9 = 1'b0;

  always #10 clk = ~clk;

  interboard_receiver #(
    .SYNC_STAGES   (2),
    .RST_TYPE      (3'd7),
    .TIMEOUT_CYCLES(16'd100)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .Request_in         (Request_in),
    .inter_data_in      (inter_data_in),
    .Ack_out            (Ack_out),
    .interboard_en      (interboard_en),
    .interboard_msg_type(interboard_msg_type),
    .interboard_number  (interboard_number),
    .interboard_rst     (interboard_rst),
    .rx_busy            (rx_busy),
    .frame_err          (frame_err)
  );

  always @(negedge clk) begin
    ack_prev <= Ack_out;
    if (Ack_out && !ack_prev) n_ack <= n_ack + 1;
    if (interboard_en) n_en <= n_en + 1;
    if (interboard_rst) n_rst <= n_rst + 1;
    if (interboard_en && interboard_rst) n_coinc <= n_coinc + 1;
    if (frame_err) n_err <= n_err + 1;
    if (interboard_number == 5'd9) seen9 <= 1'b1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [5:0] d, input int hold);
    bit ok;
    @(posedge clk);
    #1;
    inter_data_in = d;
    Request_in    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (Ack_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_rise", int'(ok), 1);
    if (hold > 0) begin
      tick(hold);
      check("ack_hold", int'(Ack_out), 1);
    end
    @(posedge clk);
    #1;
    Request_in = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!Ack_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_fall", int'(ok), 1);
    tick(3);
  endtask

  int e0, r0, c0, a0, f0;

  task automatic snap();
    e0 = n_en; r0 = n_rst; c0 = n_coinc; a0 = n_ack; f0 = n_err;
  endtask

  initial begin
    bit ok;
    rst_n         = 1'b0;
    Request_in    = 1'b0;
    inter_data_in = 6'd0;
    tick(3);
    check("rst_ack", int'(Ack_out), 0);
    check("rst_en", int'(interboard_en), 0);
    check("rst_type", int'(interboard_msg_type), 0);
    check("rst_num", int'(interboard_number), 0);
    check("rst_irst", int'(interboard_rst), 0);
    check("rst_busy", int'(rx_busy), 0);
    check("rst_err", int'(frame_err), 0);
    rst_n = 1'b1;
    tick(3);

    // Frame (2,13)
    snap();
    send_beat(6'b101001, 0);
    check("f1_busy_mid", int'(rx_busy), 1);
    check("f1_en_mid", n_en - e0, 0);
    send_beat(6'b000101, 0);
    check("f1_en", n_en - e0, 1);
    check("f1_type", int'(interboard_msg_type), 2);
    check("f1_num", int'(interboard_number), 13);
    check("f1_irst", n_rst - r0, 0);
    check("f1_acks", n_ack - a0, 2);
    check("f1_busy", int'(rx_busy), 0);
    check("f1_err", n_err - f0, 0);

    // Reset-type frame (7,0)
    snap();
    send_beat(6'b111100, 0);
    send_beat(6'b000000, 0);
    check("f2_en", n_en - e0, 1);
    check("f2_irst", n_rst - r0, 1);
    check("f2_coinc", n_coinc - c0, 1);
    check("f2_type", int'(interboard_msg_type), 7);
    check("f2_num", int'(interboard_number), 0);

    // Lone beat 1 while idle
    snap();
    send_beat(6'b000011, 0);
    check("f3_err", n_err - f0, 1);
    check("f3_en", n_en - e0, 0);
    check("f3_acks", n_ack - a0, 1);
    check("f3_type", int'(interboard_msg_type), 7);
    check("f3_num", int'(interboard_number), 0);
    check("f3_busy", int'(rx_busy), 0);

    // Resynchronise: (1,9) beat 0, then (4,25) full frame
    snap();
    send_beat(6'b100101, 0);
    send_beat(6'b110011, 0);
    check("f4_err_mid", n_err - f0, 1);
    check("f4_busy_mid", int'(rx_busy), 1);
    send_beat(6'b000001, 0);
    check("f4_err", n_err - f0, 1);
    check("f4_en", n_en - e0, 1);
    check("f4_type", int'(interboard_msg_type), 4);
    check("f4_num", int'(interboard_number), 25);
    check("f4_no9", int'(seen9), 0);

    // Request held high 20 cycles on beat 1
    snap();
    send_beat(6'b101001, 0);
    send_beat(6'b000101, 20);
    check("f5_en", n_en - e0, 1);
    check("f5_acks", n_ack - a0, 2);
    check("f5_num", int'(interboard_number), 13);

    // Reset while Ack is high
    @(posedge clk);
    #1;
    inter_data_in = 6'b101110;
    Request_in    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (Ack_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("rmid_ack_rise", int'(ok), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rmid_ack", int'(Ack_out), 0);
    check("rmid_busy", int'(rx_busy), 0);
    check("rmid_type", int'(interboard_msg_type), 0);
    Request_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    snap();
    send_beat(6'b101110, 0);
    send_beat(6'b000001, 0);
    check("f6_en", n_en - e0, 1);
    check("f6_type", int'(interboard_msg_type), 3);
    check("f6_num", int'(interboard_number), 17);
    check("f6_busy", int'(rx_busy), 0);

`ifdef INTER_RX_TIMEOUT_EN
    snap();
    send_beat(6'b110011, 0);
    tick(110);
    check("to_err", n_err - f0, 1);
    check("to_busy", int'(rx_busy), 0);
    snap();
    send_beat(6'b000001, 0);
    check("to_b1_err", n_err - f0, 1);
    check("to_b1_en", n_en - e0, 0);
`else
    snap();
    send_beat(6'b110011, 0);
    tick(120);
    check("wait_busy", int'(rx_busy), 1);
    check("wait_err", n_err - f0, 0);
    send_beat(6'b000001, 0);
    check("wait_en", n_en - e0, 1);
    check("wait_num", int'(interboard_number), 25);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interboard_receiver.md
Name: interboard_receiver

Overview:
- Receive end of the 4-phase Request/Ack interboard link between the two Bingo boards.
- Synchronises the incoming Request and 6-bit data, and reassembles each 2-beat frame into an 8-bit message: 3-bit type plus 5-bit number.
- Presents each message to the game logic as a one-cycle interboard_en pulse and drives Ack back to the remote transmitter.
- A frame with type RST_TYPE also pulses interboard_rst, which clears the keyboard, game and display blocks.

Parameters:
- SYNC_STAGES, 2, flops in the Request_in/inter_data_in synchroniser chain; minimum 2.
- RST_TYPE, 3'd7, message type that additionally pulses interboard_rst.
- TIMEOUT_CYCLES, 16'd50000, inter-beat timeout in clk cycles. Used only with INTER_RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- Request_in  in  1  remote Request, asynchronous to clk
- inter_data_in  in  6  remote data, stable while Request_in is high
- Ack_out  out  1  acknowledge to remote transmitter
- interboard_en  out  1  one-cycle pulse: new message valid
- interboard_msg_type  out  3  type of the last complete message
- interboard_number  out  5  number of the last complete message
- interboard_rst  out  1  one-cycle pulse, coincident with interboard_en, when type == RST_TYPE
- rx_busy  out  1  high from beat-0 acceptance until the frame completes or is dropped
- frame_err  out  1  one-cycle pulse on a dropped or malformed beat

Behaviour:
- Reset (async assert, sync release): Ack_out=0, interboard_en=0, interboard_msg_type=0, interboard_number=0, interboard_rst=0, rx_busy=0, frame_err=0. Synchroniser flops are cleared and the FSM goes to IDLE.
- Synchronisation:
  - Request_in and inter_data_in pass through SYNC_STAGES flops; req_s and data_s are the outputs.
  - Data is sampled only in the cycle req_s is first seen high, so data is at least SYNC_STAGES cycles old and stable.
- Frame format:
  - Beat 0: data[5]=1, data[4:2]=msg_type, data[1:0]=number[4:3].
  - Beat 1: data[5]=0, data[4:3]=2'b00, data[2:0]=number[2:0].
- FSM states: IDLE, CAP, ACK_HI, ACK_LO.
  - IDLE: Ack_out=0. On req_s=1, go to CAP.
  - CAP: one cycle. Latch data_s and classify the beat (rules below), then go to ACK_HI.
  - ACK_HI: Ack_out=1. Hold until req_s=0, then go to ACK_LO.
  - ACK_LO: Ack_out=0. Return to IDLE the next cycle, even if req_s is already 1 again, so Ack low lasts at least one cycle.
- Beat classification in CAP:
  - Expecting beat 0, data[5]=1: store type and high number bits, set beat_idx=1, rx_busy=1.
  - Expecting beat 0, data[5]=0: pulse frame_err and discard. Ack is still given so the sender is not stalled.
  - Expecting beat 1, data[5]=0: assemble the message. In the cycle after CAP: pulse interboard_en, update msg_type and number, and pulse interboard_rst if type==RST_TYPE. Then beat_idx=0, rx_busy=0.
  - Expecting beat 1, data[5]=1: pulse frame_err, drop the partial frame, and treat this beat as a new beat 0 (resynchronise).
  - data[4:3] is not checked on beat 1.
- Timing and throughput:
  - Latency from req_s rising on beat 1 to the interboard_en pulse: 2 cycles.
  - Every beat is acknowledged exactly once; Ack_out never rises while req_s is high from an earlier beat.
- Held values: interboard_msg_type and interboard_number keep their value until the next complete frame. A dropped frame never changes them.
- Reset mid-frame: all state is lost and Ack_out drops immediately. The sender must restart the frame at beat 0.
- Number range: no check; 0–31 are passed through unchanged.

Optional Feature:
- INTER_RX_TIMEOUT_EN defined:
  - A 16-bit counter runs while rx_busy=1 and the FSM is in IDLE.
  - On reaching TIMEOUT_CYCLES-1: pulse frame_err, clear beat_idx and rx_busy, clear the counter.
  - The counter is also cleared on any CAP entry.
- INTER_RX_TIMEOUT_EN not defined: no counter logic, and a partial frame waits indefinitely for beat 1.

Test Plan:
- Frame type=3'd2, number=5'd13: beats 6'b101001, then 6'b000101 with full 4-phase handshakes. Expect interboard_en pulsed once, msg_type=2, number=13, interboard_rst=0, and exactly 2 Ack_out high periods.
- Frame type=7 (RST_TYPE), number=0: beats 6'b111100, 6'b000000. Expect interboard_en and interboard_rst high in the same single cycle, and msg_type=7.
- Lone beat 6'b000011 while in IDLE with beat_idx=0: expect frame_err pulse, Ack given, no interboard_en, and outputs unchanged.
- Beat 0 for (1,9), then a new beat 0 for (4,25) instead of beat 1, then beat 1 for 25: expect frame_err once, then interboard_en with type=4, number=25. The value 9 never appears.
- Request_in held high for 20 cycles: Ack_out stays high and interboard_en fires only once. Assert rst_n=0 mid-ACK_HI: Ack_out is 0 in the same cycle, and the next frame decodes correctly.
- With INTER_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: send beat 0 only and wait 100 cycles. Expect a frame_err pulse and rx_busy=0; a following beat 1 alone gives frame_err with no interboard_en.
